// File: rtl/prbs_pkg.sv
// Shared definitions for the 4-bit PRBS (x^4+x+1) receive checker.
//   state_t          : checker FSM states (SEARCH, LOCKED)
//   DEF_TAPS         : default history mask; pred = hist[3]^hist[2]
//   DEF_LOCK_CNT     : clean non-trivial predictions needed to lock
//   DEF_UNLOCK_CNT   : consecutive mismatches in LOCKED that drop lock
//   REF_PATTERN      : one period of the sequence, MSB is sent first
package prbs_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int          DEF_WIDTH      = 4;
    localparam logic [3:0]  DEF_TAPS       = 4'b1100;
    localparam int          DEF_LOCK_CNT   = 8;
    localparam int          DEF_UNLOCK_CNT = 3;
    localparam int          DEF_CNT_W      = 16;
    localparam int          PATTERN_LEN    = 15;
    localparam logic [14:0] REF_PATTERN    = 15'b000100110101111;

endpackage

// File: rtl/prbs_predictor.sv
// Bit history and next-bit prediction for the PRBS checker.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (clears history)
//   shift_en  : shift one bit into the history this cycle
//   sel_pred  : 1 = shift the predicted bit (flywheel), 0 = shift din
//   din       : received bit
//   hist      : history; hist[k] is the bit k+1 shifts ago
//   pred      : predicted next bit, XOR of hist bits selected by TAPS
module prbs_predictor
    import prbs_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             sel_pred,
    input  logic             din,
    output logic [WIDTH-1:0] hist,
    output logic             pred
);

    logic shift_bit;

    assign pred      = ^(hist & TAPS);
    assign shift_bit = sel_pred ? pred : din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
        end else if (shift_en) begin
            hist <= {hist[WIDTH-2:0], shift_bit};
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: self-synchronises to the incoming stream,
// declares lock, then counts errored bits.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   din_valid  : qualifies din; bits are consumed only when high
//   din        : received serial bit
//   err_clr    : synchronous clear of err_cnt (applied before counting)
//   locked     : high while in LOCKED
//   err_pulse  : one-cycle pulse per errored bit seen in LOCKED
//   err_cnt    : saturating errored-bit count since reset/clear
//   sync_lost  : one-cycle pulse on the LOCKED->SEARCH transition
// All outputs are registered and reflect the bit consumed the cycle before.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS       = DEF_TAPS,
    parameter int               LOCK_CNT   = DEF_LOCK_CNT,
    parameter int               UNLOCK_CNT = DEF_UNLOCK_CNT,
    parameter int               CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic             sync_lost
);

    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_CNT - 1);

    state_t             state, state_n;
    logic [FILL_W-1:0]  fill, fill_n;
    logic [GOOD_W-1:0]  good_cnt, good_cnt_n;
    logic [BAD_W-1:0]   bad_cnt, bad_cnt_n;
    logic [CNT_W-1:0]   err_cnt_n;
    logic               err_pulse_n;
    logic               sync_lost_n;
    logic               locked_n;

    logic               shift_en;
    logic               sel_pred;
    logic [WIDTH-1:0]   hist;
    logic               pred;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    prbs_predictor #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_predictor (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .sel_pred (sel_pred),
        .din      (din),
        .hist     (hist),
        .pred     (pred)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEARCH;
            fill      <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            sync_lost <= 1'b0;
        end else begin
            state     <= state_n;
            fill      <= fill_n;
            good_cnt  <= good_cnt_n;
            bad_cnt   <= bad_cnt_n;
            locked    <= locked_n;
            err_pulse <= err_pulse_n;
            err_cnt   <= err_cnt_n;
            sync_lost <= sync_lost_n;
        end
    end

    always_comb begin
        state_n     = state;
        fill_n      = fill;
        good_cnt_n  = good_cnt;
        bad_cnt_n   = bad_cnt;
        err_pulse_n = 1'b0;
        sync_lost_n = 1'b0;
        // Clear takes effect first so a same-cycle error still lands as 1.
        err_cnt_n   = err_clr ? '0 : err_cnt;
        shift_en    = 1'b0;
        sel_pred    = 1'b0;

        if (din_valid) begin
            shift_en = 1'b1;
            case (state)
                SEARCH: begin
                    if (fill < FILL_FULL) begin
                        fill_n = fill + 1'b1;
                    end else if ((din == pred) && (hist != '0)) begin
                        // An all-zero history predicts zero forever, so a
                        // match there proves nothing and never builds lock.
                        if (good_cnt == GOOD_LAST) begin
                            state_n    = LOCKED;
                            good_cnt_n = '0;
                            bad_cnt_n  = '0;
                        end else begin
                            good_cnt_n = good_cnt + 1'b1;
                        end
                    end else begin
                        good_cnt_n = '0;
                    end
                end

                LOCKED: begin
                    // Flywheel: history advances on the prediction so a
                    // single line error is counted once, not re-propagated.
                    sel_pred = 1'b1;
                    if (din != pred) begin
                        err_pulse_n = 1'b1;
                        err_cnt_n   = sat_inc(err_cnt_n);
                        if (bad_cnt == BAD_LAST) begin
                            state_n     = SEARCH;
                            fill_n      = '0;
                            good_cnt_n  = '0;
                            bad_cnt_n   = '0;
                            sync_lost_n = 1'b1;
                        end else begin
                            bad_cnt_n = bad_cnt + 1'b1;
                        end
                    end else begin
                        bad_cnt_n = '0;
                    end
                end

                default: begin
                    state_n = SEARCH;
                    fill_n  = '0;
                end
            endcase
        end

        locked_n = (state_n == LOCKED);
    end

endmodule

// File: tb/tb_prbs_checker.sv
module tb_prbs_checker;
    import prbs_pkg::*;

    localparam int CNT_W   = 4;
    localparam int SAT_MAX = (1 << CNT_W) - 1;
    localparam int LOCK    = DEF_LOCK_CNT;
    localparam int UNLOCK  = DEF_UNLOCK_CNT;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             din_valid = 1'b0;
    logic             din = 1'b0;
    logic             err_clr = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic             sync_lost;

    int checks = 0;
    int errors = 0;

    prbs_checker #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .err_clr   (err_clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .sync_lost (sync_lost)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    // ---------------- pattern source ----------------
    bit [14:0] pat = REF_PATTERN;
    int        pidx = 0;

    function automatic bit next_pat();
        bit b;
        b    = pat[14 - pidx];
        pidx = (pidx + 1) % PATTERN_LEN;
        return b;
    endfunction

    // ---------------- reference model ----------------
    // The stream obeys s[n] = s[n-4] ^ s[n-3]; mq holds the last bits the
    // checker believes in (received while searching, predicted while locked).
    bit mq[$];
    bit m_locked;
    int m_fill, m_good, m_bad, m_err;
    bit e_pulse, e_sync;

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 4; i++) mq.push_back(1'b0);
        m_locked = 0; m_fill = 0; m_good = 0; m_bad = 0; m_err = 0;
        e_pulse = 0; e_sync = 0;
    endtask

    task automatic model_step(input bit v, input bit d, input bit clr);
        bit p, nz;
        int n;
        e_pulse = 0;
        e_sync  = 0;
        if (clr) m_err = 0;
        if (v) begin
            n  = mq.size();
            p  = mq[n-4] ^ mq[n-3];
            nz = mq[n-1] | mq[n-2] | mq[n-3] | mq[n-4];
            if (!m_locked) begin
                if (m_fill < 4) m_fill++;
                else begin
                    if (d == p && nz) m_good++;
                    else m_good = 0;
                    if (m_good == LOCK) begin
                        m_locked = 1; m_good = 0; m_bad = 0;
                    end
                end
                mq.push_back(d);
            end else begin
                if (d != p) begin
                    e_pulse = 1;
                    if (m_err < SAT_MAX) m_err++;
                    m_bad++;
                    if (m_bad == UNLOCK) begin
                        m_locked = 0; m_fill = 0; m_good = 0; m_bad = 0;
                        e_sync = 1;
                    end
                end else begin
                    m_bad = 0;
                end
                mq.push_back(p);
            end
            if (mq.size() > 4) void'(mq.pop_front());
        end
    endtask

    // Drive one cycle, advance the model, leave sampling at posedge+1.
    task automatic cycle(input bit v, input bit d, input bit clr);
        din_valid = v;
        din       = d;
        err_clr   = clr;
        @(posedge clk);
        #1;
        model_step(v, d, clr);
        din_valid = 0;
        err_clr   = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        #1;
        rst  = 0;
        pidx = 0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1;
        @(posedge clk);
        #1;
        checks++;
        if (locked !== 1'b0 || err_pulse !== 1'b0 || sync_lost !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got locked=%0b err_pulse=%0b sync_lost=%0b required 0 0 0",
                     locked, err_pulse, sync_lost);
        end
        checks++;
        if (err_cnt !== '0) begin
            errors++;
            $display("FAIL reset_err_cnt: got %0d required 0", err_cnt);
        end
        rst = 0;
        pidx = 0;
        model_reset();
    endtask

    task automatic test_lock();
        int first = 0;
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            cycle(1, next_pat(), 0);
            if (locked === 1'b1 && first == 0) first = i;
            checks++;
            if (locked !== m_locked || err_cnt !== CNT_W'(m_err)) begin
                errors++;
                $display("FAIL lock_track bit %0d: got locked=%0b err_cnt=%0d required %0b %0d",
                         i, locked, err_cnt, m_locked, m_err);
            end
        end
        checks++;
        if (first != 12) begin
            errors++;
            $display("FAIL lock_time: got bit %0d required 12", first);
        end
        checks++;
        if (err_cnt !== '0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_clean: got err_cnt=%0d locked=%0b required 0 1", err_cnt, locked);
        end
    endtask

    task automatic test_single_error();
        int pulses = 0;
        cycle(1, ~next_pat(), 0);
        checks++;
        if (err_pulse !== 1'b1 || err_cnt !== CNT_W'(1) || locked !== 1'b1) begin
            errors++;
            $display("FAIL single_hit: got pulse=%0b err_cnt=%0d locked=%0b required 1 1 1",
                     err_pulse, err_cnt, locked);
        end
        for (int i = 0; i < 45; i++) begin
            cycle(1, next_pat(), 0);
            if (err_pulse === 1'b1) pulses++;
            checks++;
            if (locked !== 1'b1) begin
                errors++;
                $display("FAIL single_locked bit %0d: got %0b required 1", i, locked);
            end
        end
        checks++;
        if (pulses != 0 || err_cnt !== CNT_W'(1)) begin
            errors++;
            $display("FAIL single_no_mult: got pulses=%0d err_cnt=%0d required 0 1", pulses, err_cnt);
        end
    endtask

    task automatic test_zero_stream();
        int first = 0;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            cycle(1, 1'b0, 0);
            checks++;
            if (locked !== 1'b0 || err_cnt !== '0) begin
                errors++;
                $display("FAIL zero_stream bit %0d: got locked=%0b err_cnt=%0d required 0 0",
                         i, locked, err_cnt);
            end
        end
        pidx = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle(1, next_pat(), 0);
            if (locked === 1'b1 && first == 0) first = i;
        end
        checks++;
        if (first == 0 || first > 12) begin
            errors++;
            $display("FAIL zero_relock: got bit %0d required 1..12", first);
        end
    endtask

    task automatic test_unlock();
        int relock = 0;
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1, next_pat(), 0);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL unlock_pre: got locked=%0b required 1", locked);
        end
        for (int k = 1; k <= 3; k++) begin
            cycle(1, ~next_pat(), 0);
            checks++;
            if (sync_lost !== (k == 3) || locked !== (k != 3) || err_pulse !== 1'b1) begin
                errors++;
                $display("FAIL unlock_bad%0d: got sync_lost=%0b locked=%0b pulse=%0b required %0b %0b 1",
                         k, sync_lost, locked, err_pulse, k == 3, k != 3);
            end
        end
        checks++;
        if (err_cnt !== CNT_W'(3)) begin
            errors++;
            $display("FAIL unlock_err_cnt: got %0d required 3", err_cnt);
        end
        for (int i = 1; i <= 40 && relock == 0; i++) begin
            cycle(1, next_pat(), 0);
            if (locked === 1'b1) relock = i;
        end
        checks++;
        if (relock != 12) begin
            errors++;
            $display("FAIL unlock_relock: got bit %0d required 12", relock);
        end
    endtask

    task automatic test_saturation_clear();
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1, next_pat(), 0);
        for (int e = 0; e < 20; e++) begin
            for (int i = 0; i < 5; i++) cycle(1, next_pat(), 0);
            cycle(1, ~next_pat(), 0);
            checks++;
            if (err_cnt !== CNT_W'(m_err)) begin
                errors++;
                $display("FAIL sat_step %0d: got %0d required %0d", e, err_cnt, m_err);
            end
        end
        checks++;
        if (err_cnt !== CNT_W'(SAT_MAX) || locked !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold: got err_cnt=%0d locked=%0b required %0d 1", err_cnt, locked, SAT_MAX);
        end
        cycle(1, next_pat(), 0);
        cycle(1, ~next_pat(), 1);
        checks++;
        if (err_cnt !== CNT_W'(1)) begin
            errors++;
            $display("FAIL clr_with_err: got %0d required 1", err_cnt);
        end
        cycle(1, next_pat(), 1);
        checks++;
        if (err_cnt !== '0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL clr_alone: got err_cnt=%0d locked=%0b required 0 1", err_cnt, locked);
        end
    endtask

    task automatic test_gaps_reset();
        int vcount = 0;
        int lock_v = 0;
        bit v;
        do_reset();
        for (int c = 0; c < 200 && lock_v == 0; c++) begin
            v = ($urandom_range(0, 2) != 0);
            cycle(v, v ? next_pat() : 1'($urandom), 0);
            if (v) vcount++;
            if (locked === 1'b1) lock_v = vcount;
            checks++;
            if (err_pulse !== e_pulse || sync_lost !== e_sync) begin
                errors++;
                $display("FAIL gaps_pulses cyc %0d: got %0b %0b required %0b %0b",
                         c, err_pulse, sync_lost, e_pulse, e_sync);
            end
        end
        checks++;
        if (lock_v != 12) begin
            errors++;
            $display("FAIL gaps_lock_point: got valid bit %0d required 12", lock_v);
        end
        for (int e = 0; e < 5; e++) begin
            cycle(1, next_pat(), 0);
            cycle(0, 1'b1, 0);
            cycle(1, ~next_pat(), 0);
        end
        checks++;
        if (err_cnt !== CNT_W'(5) || locked !== 1'b1) begin
            errors++;
            $display("FAIL gaps_err5: got err_cnt=%0d locked=%0b required 5 1", err_cnt, locked);
        end
        #2 rst = 1;
        #1;
        checks++;
        if (locked !== 1'b0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL async_reset: got locked=%0b err_cnt=%0d required 0 0", locked, err_cnt);
        end
        @(posedge clk);
        #1 rst = 0;
        pidx = 0;
        model_reset();
    endtask

    task automatic test_random();
        bit v, d, clr;
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            v   = ($urandom_range(0, 99) < 80);
            clr = ($urandom_range(0, 99) < 2);
            if (v) begin
                if ($urandom_range(0, 199) == 0) void'(next_pat());
                d = next_pat() ^ ($urandom_range(0, 99) < 5);
            end else begin
                d = 1'($urandom);
            end
            cycle(v, d, clr);
            checks++;
            if (locked !== m_locked || err_pulse !== e_pulse || sync_lost !== e_sync ||
                err_cnt !== CNT_W'(m_err)) begin
                errors++;
                $display("FAIL random cyc %0d: got %0b %0b %0b %0d required %0b %0b %0b %0d",
                         c, locked, err_pulse, sync_lost, err_cnt, m_locked, e_pulse, e_sync, m_err);
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_lock();
        test_single_error();
        test_zero_stream();
        test_unlock();
        test_saturation_clear();
        test_gaps_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
